// File: rtl/gol_engine_if.sv
// Command/status bundle between a controller and the Game-of-Life engine.
interface gol_engine_if #(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int GEN_W = 16
);
  logic                   load;
  logic [ROWS*COLS-1:0]   grid_in;
  logic                   step;
  logic                   run;
  logic                   halt_stable;
  logic [ROWS*COLS-1:0]   grid_out;
  logic [GEN_W-1:0]       gen_count;
  logic                   evolve_valid;
  logic                   busy;
  logic                   stable;
  logic                   extinct;

  modport master (
    output load, grid_in, step, run, halt_stable,
    input  grid_out, gen_count, evolve_valid, busy, stable, extinct
  );

  modport slave (
    input  load, grid_in, step, run, halt_stable,
    output grid_out, gen_count, evolve_valid, busy, stable, extinct
  );
endinterface

// File: rtl/gol_engine.sv
// Conway Game-of-Life engine: whole ROWS x COLS grid in registers, one
// B3/S23 generation per clock, toroidal or dead-boundary edges.
module gol_engine #(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int WRAP  = 1,
  parameter int GEN_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  gol_engine_if.slave bus
);
  localparam int N = ROWS * COLS;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [N-1:0]       grid_q, grid_d;
  logic [N-1:0]       next_grid;
  logic [GEN_W-1:0]   gen_q, gen_d;
  logic               ev_q, ev_d;
  logic               upd;
  logic               stable_w;

  // Per-cell neighbour count and B3/S23 rule; edge handling is resolved at
  // elaboration so every neighbour tap is a fixed wire or a constant 0.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int RM = (r + ROWS - 1) % ROWS;
      localparam int RP = (r + 1) % ROWS;
      localparam int CM = (c + COLS - 1) % COLS;
      localparam int CP = (c + 1) % COLS;
      localparam bit VN = (WRAP != 0) || (r > 0);
      localparam bit VS = (WRAP != 0) || (r < ROWS - 1);
      localparam bit VW = (WRAP != 0) || (c > 0);
      localparam bit VE = (WRAP != 0) || (c < COLS - 1);

      logic [7:0] nb;
      logic [3:0] cnt;

      assign nb[0] = (VN && VW) ? grid_q[RM*COLS + CM] : 1'b0;
      assign nb[1] =  VN        ? grid_q[RM*COLS + c ] : 1'b0;
      assign nb[2] = (VN && VE) ? grid_q[RM*COLS + CP] : 1'b0;
      assign nb[3] =  VW        ? grid_q[r*COLS  + CM] : 1'b0;
      assign nb[4] =  VE        ? grid_q[r*COLS  + CP] : 1'b0;
      assign nb[5] = (VS && VW) ? grid_q[RP*COLS + CM] : 1'b0;
      assign nb[6] =  VS        ? grid_q[RP*COLS + c ] : 1'b0;
      assign nb[7] = (VS && VE) ? grid_q[RP*COLS + CP] : 1'b0;

      assign cnt = 4'($countones(nb));
      assign next_grid[r*COLS + c] = (cnt == 4'd3) ||
                                     (grid_q[r*COLS + c] && (cnt == 4'd2));
    end
  end

  assign stable_w = (next_grid == grid_q);

  // Command sequencing and generation update; load overrides every state.
  always_comb begin
    state_d = state_q;
    grid_d  = grid_q;
    gen_d   = gen_q;
    ev_d    = 1'b0;
    upd     = 1'b0;
    if (bus.load) begin
      grid_d  = bus.grid_in;
      gen_d   = '0;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.run)       state_d = S_RUN;
          else if (bus.step) upd     = 1'b1;
        end
        S_RUN: begin
          if (!bus.run)                        state_d = S_IDLE;
          else if (bus.halt_stable && stable_w) state_d = S_DONE;
          else                                  upd     = 1'b1;
        end
        S_DONE: begin
          if (!bus.run) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
      if (upd) begin
        grid_d = next_grid;
        gen_d  = (gen_q == '1) ? gen_q : gen_q + 1'b1;
        ev_d   = 1'b1;
      end
    end
  end

  // State, grid and counter registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      grid_q  <= '0;
      gen_q   <= '0;
      ev_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grid_q  <= grid_d;
      gen_q   <= gen_d;
      ev_q    <= ev_d;
    end
  end

  assign bus.grid_out     = grid_q;
  assign bus.gen_count    = gen_q;
  assign bus.evolve_valid = ev_q;
  assign bus.busy         = (state_q == S_RUN);
  assign bus.stable       = stable_w;
  assign bus.extinct      = (grid_q == '0);
endmodule

// File: tb/tb_gol_engine.sv
// Bench for gol_engine: three instances (16x16 toroidal, 16x16 dead edge,
// 8x12 dead edge with a 4-bit counter) share one command stream and are each
// compared every cycle against a cell-by-cell reference model.
module tb_gol_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         load = 1'b0, step = 1'b0, run = 1'b0, halt = 1'b0;
  logic [255:0] seed = '0;

  gol_engine_if #(.ROWS(16), .COLS(16), .GEN_W(16)) b0 ();
  gol_engine_if #(.ROWS(16), .COLS(16), .GEN_W(16)) b1 ();
  gol_engine_if #(.ROWS(8),  .COLS(12), .GEN_W(4))  b2 ();

  assign b0.load = load; assign b0.step = step; assign b0.run = run;
  assign b0.halt_stable = halt; assign b0.grid_in = seed;
  assign b1.load = load; assign b1.step = step; assign b1.run = run;
  assign b1.halt_stable = halt; assign b1.grid_in = seed;
  assign b2.load = load; assign b2.step = step; assign b2.run = run;
  assign b2.halt_stable = halt; assign b2.grid_in = seed[95:0];

  gol_engine #(.ROWS(16), .COLS(16), .WRAP(1), .GEN_W(16)) u0 (.clk(clk), .reset(rst_n), .bus(b0.slave));
  gol_engine #(.ROWS(16), .COLS(16), .WRAP(0), .GEN_W(16)) u1 (.clk(clk), .reset(rst_n), .bus(b1.slave));
  gol_engine #(.ROWS(8),  .COLS(12), .WRAP(0), .GEN_W(4))  u2 (.clk(clk), .reset(rst_n), .bus(b2.slave));

  int checks = 0;
  int errors = 0;

  // Reference model state per instance: 0 idle, 1 running, 2 done.
  int           R[3]    = '{16, 16, 8};
  int           C[3]    = '{16, 16, 12};
  int           W[3]    = '{1, 0, 0};
  int           GMAX[3] = '{65535, 65535, 15};
  logic [255:0] mg[3];
  int           mgen[3];
  int           mst[3];
  bit           mev[3];

  function automatic bit cell_at(logic [255:0] g, int r, int c, int rows, int cols, int wrap);
    if (wrap != 0) begin
      r = (r + rows) % rows;
      c = (c + cols) % cols;
    end else if (r < 0 || r >= rows || c < 0 || c >= cols) begin
      return 1'b0;
    end
    return g[r*cols + c];
  endfunction

  function automatic logic [255:0] life(logic [255:0] g, int rows, int cols, int wrap);
    logic [255:0] n = '0;
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++) begin
        int cnt = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (dr != 0 || dc != 0) cnt += int'(cell_at(g, r + dr, c + dc, rows, cols, wrap));
        n[r*cols + c] = (cnt == 3) || (g[r*cols + c] && cnt == 2);
      end
    return n;
  endfunction

  function automatic logic [255:0] mask(int k);
    return (256'(1) << (R[k] * C[k])) - 256'(1);
  endfunction

  function automatic logic [255:0] at(int r, int c, int cols);
    return 256'(1) << (r * cols + c);
  endfunction

  task automatic chk(string tag, int k, logic [255:0] obs, logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d got %h want %h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mg[k] = '0; mgen[k] = 0; mst[k] = 0; mev[k] = 1'b0;
    end
  endtask

  // Apply the command rules to the model for the edge about to happen.
  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      logic [255:0] nxt = life(mg[k], R[k], C[k], W[k]);
      bit upd = 1'b0;
      if (load) begin
        mg[k] = seed & mask(k); mgen[k] = 0; mst[k] = 0; mev[k] = 1'b0;
      end else begin
        if (mst[k] == 0) begin
          if (run) mst[k] = 1; else if (step) upd = 1'b1;
        end else if (mst[k] == 1) begin
          if (!run) mst[k] = 0;
          else if (halt && nxt == mg[k]) mst[k] = 2;
          else upd = 1'b1;
        end else if (!run) begin
          mst[k] = 0;
        end
        mev[k] = upd;
        if (upd) begin
          mg[k] = nxt;
          if (mgen[k] < GMAX[k]) mgen[k]++;
        end
      end
    end
  endtask

  task automatic check_all(string tag);
    logic [255:0] og[3], ogen[3];
    logic         oev[3], obusy[3], ost[3], oex[3];
    og[0] = b0.grid_out; ogen[0] = 256'(b0.gen_count); oev[0] = b0.evolve_valid;
    obusy[0] = b0.busy; ost[0] = b0.stable; oex[0] = b0.extinct;
    og[1] = b1.grid_out; ogen[1] = 256'(b1.gen_count); oev[1] = b1.evolve_valid;
    obusy[1] = b1.busy; ost[1] = b1.stable; oex[1] = b1.extinct;
    og[2] = 256'(b2.grid_out); ogen[2] = 256'(b2.gen_count); oev[2] = b2.evolve_valid;
    obusy[2] = b2.busy; ost[2] = b2.stable; oex[2] = b2.extinct;
    for (int k = 0; k < 3; k++) begin
      chk({tag, ".grid"},    k, og[k], mg[k]);
      chk({tag, ".gen"},     k, ogen[k], 256'(mgen[k]));
      chk({tag, ".valid"},   k, 256'(oev[k]), 256'(mev[k]));
      chk({tag, ".busy"},    k, 256'(obusy[k]), 256'(mst[k] == 1));
      chk({tag, ".stable"},  k, 256'(ost[k]), 256'(life(mg[k], R[k], C[k], W[k]) == mg[k]));
      chk({tag, ".extinct"}, k, 256'(oex[k]), 256'(mg[k] == '0));
    end
  endtask

  task automatic tick(string tag);
    model_edge();
    @(posedge clk);
    #1;
    step = 1'b0;
    load = 1'b0;
    check_all(tag);
  endtask

  logic [255:0] blinker, glider;

  initial begin
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick("idle_after_reset");

    // Blinker: horizontal at row 5 cols 4..6 oscillates with period 2.
    blinker = at(5, 4, 16) | at(5, 5, 16) | at(5, 6, 16);
    seed = blinker; load = 1'b1; tick("blink_load");
    step = 1'b1; tick("blink_step1");
    chk("blink_vertical", 0, b0.grid_out, at(4, 5, 16) | at(5, 5, 16) | at(6, 5, 16));
    chk("blink_gen1", 0, 256'(b0.gen_count), 256'(1));
    chk("blink_valid", 0, 256'(b0.evolve_valid), 256'(1));
    tick("blink_idle");
    chk("blink_valid_drop", 0, 256'(b0.evolve_valid), 256'(0));
    step = 1'b1; tick("blink_step2");
    chk("blink_back", 0, b0.grid_out, blinker);
    chk("blink_gen2", 0, 256'(b0.gen_count), 256'(2));
    chk("blink_unstable", 0, 256'(b0.stable), 256'(0));

    // Block still-life halts RUN without updating.
    seed = at(0, 0, 16) | at(0, 1, 16) | at(1, 0, 16) | at(1, 1, 16);
    load = 1'b1; tick("block_load");
    run = 1'b1; halt = 1'b1;
    tick("block_enter_run");
    tick("block_done");
    chk("block_busy", 1, 256'(b1.busy), 256'(0));
    chk("block_gen", 1, 256'(b1.gen_count), 256'(0));
    run = 1'b0; halt = 1'b0; tick("block_leave");
    seed = at(15, 15, 16) | at(15, 0, 16) | at(0, 15, 16) | at(0, 0, 16);
    load = 1'b1; tick("block_wrap_load");
    chk("block_wrap_stable", 0, 256'(b0.stable), 256'(1));

    // Glider returns to its seed after 64 generations on the 16x16 torus.
    glider = at(0, 1, 16) | at(1, 2, 16) | at(2, 0, 16) | at(2, 1, 16) | at(2, 2, 16);
    seed = glider; load = 1'b1; tick("glider_load");
    run = 1'b1;
    for (int i = 0; i < 65; i++) tick("glider_run");
    run = 1'b0; tick("glider_stop");
    chk("glider_home", 0, b0.grid_out, glider);
    chk("glider_gen", 0, 256'(b0.gen_count), 256'(64));
    checks++;
    assert (b1.grid_out !== glider) else begin
      errors++;
      $error("FAIL glider_nowrap dut1 got %h want not %h", b1.grid_out, glider);
    end
    chk("gen_saturate", 2, 256'(b2.gen_count), 256'(15));

    // Lone cell dies.
    seed = at(7, 7, 16); load = 1'b1; tick("lone_load");
    step = 1'b1; tick("lone_step");
    chk("lone_grid", 0, b0.grid_out, '0);
    chk("lone_extinct", 0, 256'(b0.extinct), 256'(1));
    chk("lone_stable", 0, 256'(b0.stable), 256'(1));
    chk("lone_gen", 0, 256'(b0.gen_count), 256'(1));

    // Load during RUN wins, then RUN resumes.
    seed = blinker; load = 1'b1; tick("prio_seed");
    run = 1'b1;
    for (int i = 0; i < 11; i++) tick("prio_run");
    chk("prio_gen10", 0, 256'(b0.gen_count), 256'(10));
    load = 1'b1; tick("prio_load");
    chk("prio_gen0", 0, 256'(b0.gen_count), 256'(0));
    chk("prio_idle", 0, 256'(b0.busy), 256'(0));
    tick("prio_reenter");
    chk("prio_busy", 0, 256'(b0.busy), 256'(1));
    tick("prio_update");
    chk("prio_gen1", 0, 256'(b0.gen_count), 256'(1));

    // Asynchronous reset mid-cycle while running.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_grid", 0, b0.grid_out, '0);
    check_all("async_reset");
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick("post_reset");

    // 8x12 dead edge: vertical blinker on column 0 loses its off-grid arm.
    seed = at(3, 0, 12) | at(4, 0, 12) | at(5, 0, 12);
    load = 1'b1; tick("edge_load");
    step = 1'b1; tick("edge_step");
    chk("edge_grid", 2, 256'(b2.grid_out), at(4, 0, 12) | at(4, 1, 12));
    chk("edge_gen", 2, 256'(b2.gen_count), 256'(1));

    // Random command stream and seeds.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        for (int w = 0; w < 8; w++) seed[w*32 +: 32] = $urandom() & $urandom();
        load = 1'b1;
      end
      step = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) run = ~run;
      halt = $urandom_range(0, 1) != 0;
      tick("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "bench did not finish");
  end
endmodule
